// File: rtl/bsg_mem_nr1w_pkg.sv
// Shared constants and helpers for the multi-read-port synchronous register file.
package bsg_mem_nr1w_pkg;

  localparam int e_bypass_off = 0;
  localparam int e_bypass_on  = 1;

  // Address width that stays at least one bit wide for single-entry memories.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // LSB offset of port 'port' inside a packed per-port bus of 'w'-bit fields.
  function automatic int slice_lsb(input int port, input int w);
    return port * w;
  endfunction

endpackage

// File: rtl/bsg_mem_nr1w_sync_if.sv
// Bus bundle between a client and the nr1w memory: one masked write port and
// num_rd_p read ports packed side by side.
interface bsg_mem_nr1w_sync_if #(
  parameter int width_p  = 8,
  parameter int els_p    = 6,
  parameter int num_rd_p = 1,
  localparam int addr_width_lp = bsg_mem_nr1w_pkg::safe_clog2(els_p)
);
  // Handshake: w_v_i commits a write at the rising edge it is seen on; r_v_i[i]
  // is a request that is always accepted, and r_v_o[i] marks the result one
  // cycle later. There is no backpressure in either direction.
  logic                               w_v_i;
  logic [addr_width_lp-1:0]           w_addr_i;
  logic [width_p-1:0]                 w_data_i;
  logic [width_p-1:0]                 w_mask_i;
  logic [num_rd_p-1:0]                r_v_i;
  logic [num_rd_p*addr_width_lp-1:0]  r_addr_i;
  logic [num_rd_p*width_p-1:0]        r_data_o;
  logic [num_rd_p-1:0]                r_v_o;
  logic [num_rd_p-1:0]                r_init_o;
  logic                               err_o;

  modport master (
    output w_v_i, w_addr_i, w_data_i, w_mask_i, r_v_i, r_addr_i,
    input  r_data_o, r_v_o, r_init_o, err_o
  );

  modport slave (
    input  w_v_i, w_addr_i, w_data_i, w_mask_i, r_v_i, r_addr_i,
    output r_data_o, r_v_o, r_init_o, err_o
  );
endinterface

// File: rtl/bsg_mem_nr1w_read_port.sv
// One synchronous read port: range check, write collision mux and the
// registered data/valid/init outputs.
module bsg_mem_nr1w_read_port
  import bsg_mem_nr1w_pkg::*;
#(
  parameter int width_p       = 8,
  parameter int els_p         = 6,
  parameter int bypass_p      = e_bypass_off,
  parameter int addr_width_lp = safe_clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     r_v,
  input  logic [addr_width_lp-1:0] r_addr,
  input  logic [width_p-1:0]       entry_data,
  input  logic                     entry_init,
  input  logic                     w_v,
  input  logic [addr_width_lp-1:0] w_addr,
  input  logic [width_p-1:0]       w_merged,
  input  logic                     w_init_set,
  output logic [width_p-1:0]       q_data,
  output logic                     q_v,
  output logic                     q_init,
  output logic                     oor
);

  logic               in_range;
  logic               collide;
  logic               use_bypass;
  logic [width_p-1:0] next_data;
  logic               next_init;

  assign in_range   = 32'(r_addr) < 32'(els_p);
  assign collide    = w_v & in_range & (w_addr == r_addr);
  assign use_bypass = (bypass_p == e_bypass_on) && collide;

  // Without bypass the array still holds pre-write contents this cycle, so the
  // plain entry lookup already yields the old value on a collision.
  assign next_data = !in_range  ? '0 :
                     use_bypass ? w_merged : entry_data;
  assign next_init = in_range & (use_bypass ? (entry_init | w_init_set) : entry_init);
  assign oor       = r_v & ~in_range;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      q_v    <= 1'b0;
      q_data <= '0;
      q_init <= 1'b0;
    end else begin
      q_v <= r_v;
      if (r_v) begin
        q_data <= next_data;
        q_init <= next_init;
      end
    end
  end

endmodule

// File: rtl/bsg_mem_nr1w_sync.sv
// Register file with one masked write port, num_rd_p 1-cycle synchronous read
// ports, per-entry written-since-reset bits and a sticky out-of-range flag.
module bsg_mem_nr1w_sync
  import bsg_mem_nr1w_pkg::*;
#(
  parameter int width_p  = 8,
  parameter int els_p    = 6,
  parameter int num_rd_p = 1,
  parameter int bypass_p = e_bypass_off,
  localparam int addr_width_lp = safe_clog2(els_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  bsg_mem_nr1w_sync_if.slave   mem_if
);

  if (width_p <= 0 || els_p <= 0 || num_rd_p <= 0) begin : g_bad_params
    $error("bsg_mem_nr1w_sync: width_p, els_p and num_rd_p must all be positive");
  end

  logic [width_p-1:0]  mem [els_p];
  logic [els_p-1:0]    init_r;
  logic                err_r;
  logic                w_in_range;
  logic                w_commit;
  logic                w_init_set;
  logic [width_p-1:0]  w_merged;
  logic [num_rd_p-1:0] rd_err;

  assign w_in_range = 32'(mem_if.w_addr_i) < 32'(els_p);
  assign w_commit   = mem_if.w_v_i & w_in_range;
  assign w_init_set = |mem_if.w_mask_i;
  assign w_merged   = (mem[mem_if.w_addr_i] & ~mem_if.w_mask_i)
                    | (mem_if.w_data_i & mem_if.w_mask_i);

  // The array has no reset value; it only has to hold still while reset is low.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      init_r <= '0;
      err_r  <= 1'b0;
    end else begin
      if (w_commit) begin
        mem[mem_if.w_addr_i] <= w_merged;
        if (w_init_set) init_r[mem_if.w_addr_i] <= 1'b1;
      end
      if ((mem_if.w_v_i & ~w_in_range) | (|rd_err)) err_r <= 1'b1;
    end
  end

  assign mem_if.err_o = err_r;

  for (genvar i = 0; i < num_rd_p; i++) begin : g_rd
    localparam int a_lsb = slice_lsb(i, addr_width_lp);
    localparam int d_lsb = slice_lsb(i, width_p);

    logic [addr_width_lp-1:0] r_addr;
    logic [width_p-1:0]       entry_data;
    logic                     entry_init;
    logic [width_p-1:0]       q_data;
    logic                     q_v;
    logic                     q_init;

    assign r_addr     = mem_if.r_addr_i[a_lsb +: addr_width_lp];
    assign entry_data = mem[r_addr];
    assign entry_init = init_r[r_addr];

    bsg_mem_nr1w_read_port #(
      .width_p      (width_p),
      .els_p        (els_p),
      .bypass_p     (bypass_p),
      .addr_width_lp(addr_width_lp)
    ) u_rd (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .r_v        (mem_if.r_v_i[i]),
      .r_addr     (r_addr),
      .entry_data (entry_data),
      .entry_init (entry_init),
      .w_v        (mem_if.w_v_i),
      .w_addr     (mem_if.w_addr_i),
      .w_merged   (w_merged),
      .w_init_set (w_init_set),
      .q_data     (q_data),
      .q_v        (q_v),
      .q_init     (q_init),
      .oor        (rd_err[i])
    );

    assign mem_if.r_data_o[d_lsb +: width_p] = q_data;
    assign mem_if.r_v_o[i]                   = q_v;
    assign mem_if.r_init_o[i]                = q_init;
  end

  // Valid strobes must be known whenever the memory is out of reset.
  a_valid_known: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                  !$isunknown({mem_if.w_v_i, mem_if.r_v_i}))
    else $error("bsg_mem_nr1w_sync: X on w_v_i or r_v_i");

endmodule

// File: tb/tb_bsg_mem_nr1w_sync.sv
// Bench for bsg_mem_nr1w_sync: two instances (bypass off / on) driven with the
// same stimulus and checked against a behavioural model through a result queue.
module tb_bsg_mem_nr1w_sync;
  import bsg_mem_nr1w_pkg::*;

  localparam int W  = 8;
  localparam int N  = 6;
  localparam int NR = 2;
  localparam int AW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic           w_v = 1'b0;
  logic [AW-1:0]  w_addr = '0;
  logic [W-1:0]   w_data = '0;
  logic [W-1:0]   w_mask = '0;
  logic [NR-1:0]  r_v = '0;
  logic [NR*AW-1:0] r_addr = '0;

  bsg_mem_nr1w_sync_if #(.width_p(W), .els_p(N), .num_rd_p(NR)) if0 ();
  bsg_mem_nr1w_sync_if #(.width_p(W), .els_p(N), .num_rd_p(NR)) if1 ();

  assign if0.w_v_i = w_v;  assign if0.w_addr_i = w_addr; assign if0.w_data_i = w_data;
  assign if0.w_mask_i = w_mask; assign if0.r_v_i = r_v; assign if0.r_addr_i = r_addr;
  assign if1.w_v_i = w_v;  assign if1.w_addr_i = w_addr; assign if1.w_data_i = w_data;
  assign if1.w_mask_i = w_mask; assign if1.r_v_i = r_v; assign if1.r_addr_i = r_addr;

  bsg_mem_nr1w_sync #(.width_p(W), .els_p(N), .num_rd_p(NR), .bypass_p(e_bypass_off)) dut0 (
    .clk_i(clk), .reset_n_i(reset_n), .mem_if(if0));
  bsg_mem_nr1w_sync #(.width_p(W), .els_p(N), .num_rd_p(NR), .bypass_p(e_bypass_on)) dut1 (
    .clk_i(clk), .reset_n_i(reset_n), .mem_if(if1));

  // slot k = dut*2 + port, each slot {r_v_o, r_init_o, r_data_o}
  logic [39:0] got_w;
  assign got_w = {if1.r_v_o[1], if1.r_init_o[1], if1.r_data_o[15:8],
                  if1.r_v_o[0], if1.r_init_o[0], if1.r_data_o[7:0],
                  if0.r_v_o[1], if0.r_init_o[1], if0.r_data_o[15:8],
                  if0.r_v_o[0], if0.r_init_o[0], if0.r_data_o[7:0]};

  // ---------------- scoreboard / model ----------------
  int total = 0;
  int bad   = 0;
  logic [39:0] exp_q[$];
  logic [W-1:0] m_mem [N];
  logic [N-1:0] m_init;
  logic         m_err;
  logic [W-1:0] last_d [2][NR];
  logic         last_i [2][NR];

  function automatic logic [W-1:0] merge(input logic [W-1:0] old);
    return (old & ~w_mask) | (w_data & w_mask);
  endfunction

  task automatic model_reset();
    m_init = '0;
    m_err  = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < NR; p++) begin
        last_d[d][p] = '0;
        last_i[d][p] = 1'b0;
      end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_write(input int a, input logic [W-1:0] d, input logic [W-1:0] m);
    w_v = 1'b1; w_addr = AW'(a); w_data = d; w_mask = m;
  endtask

  task automatic set_read(input int p, input int a);
    r_v[p] = 1'b1;
    r_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic clear_inputs();
    w_v = 1'b0; w_addr = '0; w_data = '0; w_mask = '0; r_v = '0; r_addr = '0;
  endtask

  // Predict this cycle's results, apply the model write, clock, then compare.
  task automatic tick(input string name);
    logic [39:0] e;
    logic [9:0]  ex, gt;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < NR; p++) begin
        logic [AW-1:0] a;
        logic [W-1:0]  dv;
        logic          iv;
        a = r_addr[p*AW +: AW];
        if (r_v[p]) begin
          if (int'(a) >= N) begin
            dv = '0; iv = 1'b0;
          end else if (d == 1 && w_v && w_addr == a) begin
            dv = merge(m_mem[a]); iv = m_init[a] | (|w_mask);
          end else begin
            dv = m_mem[a]; iv = m_init[a];
          end
          last_d[d][p] = dv;
          last_i[d][p] = iv;
        end else begin
          dv = last_d[d][p]; iv = last_i[d][p];
        end
        e[(d*2+p)*10 +: 10] = {r_v[p], iv, dv};
      end
    exp_q.push_back(e);
    if (w_v) begin
      if (int'(w_addr) < N) begin
        m_mem[w_addr] = merge(m_mem[w_addr]);
        if (|w_mask) m_init[w_addr] = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
    for (int p = 0; p < NR; p++)
      if (r_v[p] && int'(r_addr[p*AW +: AW]) >= N) m_err = 1'b1;

    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    for (int k = 0; k < 4; k++) begin
      ex = e[k*10 +: 10];
      gt = got_w[k*10 +: 10];
      total++;
      if (gt[9] !== ex[9]) begin
        bad++;
        $display("FAIL %s r_v_o slot%0d got=%b exp=%b", name, k, gt[9], ex[9]);
      end
      total++;
      if (gt[8] !== ex[8]) begin
        bad++;
        $display("FAIL %s r_init_o slot%0d got=%b exp=%b", name, k, gt[8], ex[8]);
      end
      if (!$isunknown(ex[7:0])) begin
        total++;
        if (gt[7:0] !== ex[7:0]) begin
          bad++;
          $display("FAIL %s r_data_o slot%0d got=%h exp=%h", name, k, gt[7:0], ex[7:0]);
        end
      end
    end
    total++;
    if (if0.err_o !== m_err || if1.err_o !== m_err) begin
      bad++;
      $display("FAIL %s err_o got=%b/%b exp=%b", name, if0.err_o, if1.err_o, m_err);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    clear_inputs();
    model_reset();
    #1;
    total++;
    if (got_w !== 40'h0 || if0.err_o !== 1'b0 || if1.err_o !== 1'b0) begin
      bad++;
      $display("FAIL reset outputs got=%h err=%b/%b exp=0", got_w, if0.err_o, if1.err_o);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset_read();
    set_read(0, 3); set_read(1, 3);
    tick("reset_read");
    clear_inputs();
    total++;
    if (if0.r_v_o !== 2'b11 || if0.r_init_o !== 2'b00 || if0.err_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_read_const got v=%b init=%b err=%b exp v=11 init=00 err=0",
               if0.r_v_o, if0.r_init_o, if0.err_o);
    end
  endtask

  task automatic test_masked_write();
    set_write(2, 8'hFF, 8'hFF); tick("mw_full");
    set_write(2, 8'h00, 8'h0F); tick("mw_low");
    clear_inputs();
    set_read(0, 2); set_read(1, 2);
    tick("mw_read");
    clear_inputs();
    total++;
    if (if0.r_data_o[7:0] !== 8'hF0 || if0.r_init_o[0] !== 1'b1) begin
      bad++;
      $display("FAIL mw_const got data=%h init=%b exp data=f0 init=1",
               if0.r_data_o[7:0], if0.r_init_o[0]);
    end
  endtask

  task automatic test_collision();
    set_write(4, 8'h11, 8'hFF); tick("col_seed");
    set_write(4, 8'h22, 8'hFF); set_read(0, 4); set_read(1, 4);
    tick("col_same");
    clear_inputs();
    total++;
    if (if0.r_data_o !== 16'h1111 || if1.r_data_o !== 16'h2222) begin
      bad++;
      $display("FAIL col_const got byp0=%h byp1=%h exp byp0=1111 byp1=2222",
               if0.r_data_o, if1.r_data_o);
    end
    set_read(0, 4);
    tick("col_after");
    clear_inputs();
    total++;
    if (if0.r_data_o[7:0] !== 8'h22) begin
      bad++;
      $display("FAIL col_after_const got=%h exp=22", if0.r_data_o[7:0]);
    end
    // Collision with a partial mask on an entry that was never written.
    set_write(5, 8'h5A, 8'hF0); set_read(1, 5);
    tick("col_init");
    clear_inputs();
  endtask

  task automatic test_hold();
    set_write(1, 8'hA5, 8'hFF); tick("hold_seed");
    clear_inputs();
    set_read(0, 1); tick("hold_read");
    clear_inputs();
    repeat (3) tick("hold_idle");
    total++;
    if (if0.r_v_o[0] !== 1'b0 || if0.r_data_o[7:0] !== 8'hA5) begin
      bad++;
      $display("FAIL hold_const got v=%b data=%h exp v=0 data=a5",
               if0.r_v_o[0], if0.r_data_o[7:0]);
    end
    set_write(0, 8'h3C, 8'hFF); tick("indep_seed");
    clear_inputs();
    set_read(0, 0); set_read(1, 1);
    tick("indep_read");
    clear_inputs();
    total++;
    if (if0.r_data_o !== 16'hA53C) begin
      bad++;
      $display("FAIL indep_const got=%h exp=a53c", if0.r_data_o);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      w_v    = 1'($urandom_range(0, 1));
      w_addr = AW'($urandom_range(0, N-1));
      w_data = W'($urandom_range(0, 255));
      case ($urandom_range(0, 3))
        0:       w_mask = 8'h00;
        1:       w_mask = 8'hFF;
        default: w_mask = W'($urandom_range(0, 255));
      endcase
      for (int p = 0; p < NR; p++) begin
        r_v[p] = 1'($urandom_range(0, 1));
        r_addr[p*AW +: AW] = ($urandom_range(0, 1) == 1) ? w_addr
                                                          : AW'($urandom_range(0, N-1));
      end
      tick("random");
    end
    clear_inputs();
  endtask

  task automatic test_out_of_range();
    set_write(7, 8'hEE, 8'hFF); tick("oor_write");
    clear_inputs();
    total++;
    if (if0.err_o !== 1'b1) begin
      bad++;
      $display("FAIL oor_write_err got=%b exp=1", if0.err_o);
    end
    set_read(0, 6); tick("oor_read");
    clear_inputs();
    total++;
    if (if0.r_v_o[0] !== 1'b1 || if0.r_data_o[7:0] !== 8'h00 || if0.r_init_o[0] !== 1'b0) begin
      bad++;
      $display("FAIL oor_read_const got v=%b data=%h init=%b exp v=1 data=00 init=0",
               if0.r_v_o[0], if0.r_data_o[7:0], if0.r_init_o[0]);
    end
    repeat (100) tick("err_sticky");
    for (int a = 0; a < N; a++) begin
      set_read(0, a); set_read(1, a);
      tick("oor_no_change");
    end
    clear_inputs();
  endtask

  task automatic test_mid_reset();
    set_read(0, 2); tick("mid_pre");
    clear_inputs();
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (if0.r_v_o !== 2'b00 || if0.r_data_o !== 16'h0 || if0.err_o !== 1'b0 ||
        if1.r_v_o !== 2'b00 || if1.err_o !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got v=%b data=%h err=%b exp all 0",
               if0.r_v_o, if0.r_data_o, if0.err_o);
    end
    set_write(3, 8'h77, 8'hFF);
    set_read(0, 3);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    clear_inputs();
    set_read(0, 3); set_read(1, 3);
    tick("mid_after");
    clear_inputs();
    total++;
    if (if0.r_init_o !== 2'b00) begin
      bad++;
      $display("FAIL mid_init_const got=%b exp=00", if0.r_init_o);
    end
  endtask

  initial begin
    for (int a = 0; a < N; a++) m_mem[a] = 'x;
    test_reset();
    test_reset_read();
    test_masked_write();
    test_collision();
    test_hold();
    test_random();
    test_out_of_range();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
